// File: rtl/nv_nvdla_glb_pkg.sv
// Shared constants for the global interrupt sequencer: source sizing,
// unit/group source-index map and the sequencer state encoding.
package nv_nvdla_glb_pkg;

    localparam int NUM_UNITS   = 8;
    localparam int NUM_GROUPS  = 2;
    localparam int SEQ_NUM_SRC = NUM_UNITS * NUM_GROUPS;
    localparam int SEQ_CNT_W   = 2;

    // Engine units; source index = 2*unit + group
    localparam int UNIT_SDP      = 0;
    localparam int UNIT_CDP      = 1;
    localparam int UNIT_PDP      = 2;
    localparam int UNIT_BDMA     = 3;
    localparam int UNIT_RUBIK    = 4;
    localparam int UNIT_CDMA_DAT = 5;
    localparam int UNIT_CDMA_WT  = 6;
    localparam int UNIT_CACC     = 7;

    localparam int GROUP0 = 0;
    localparam int GROUP1 = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } seq_state_t;

    function automatic int src_index(input int unit, input int group);
        return NUM_GROUPS * unit + group;
    endfunction

endpackage

// File: rtl/nv_nvdla_glb_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping modulo N.
module nv_nvdla_glb_rr_arb #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_glb_intr_seq.sv
// Collects engine done strobes into per-source saturating counters and
// offers them one at a time, round-robin, to the interrupt controller.
module nv_nvdla_glb_intr_seq
    import nv_nvdla_glb_pkg::*;
#(
    parameter  int NUM_SRC = SEQ_NUM_SRC,
    parameter  int CNT_W   = SEQ_CNT_W,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               seq_en,
    input  logic [NUM_SRC-1:0] done_pulse,
    input  logic [NUM_SRC-1:0] ovf_clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [NUM_SRC-1:0] ovf,
    output logic               pend_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [ID_W-1:0]    r_evt_id;
    logic [ID_W-1:0]    w_evt_id_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_next;
    logic [NUM_SRC-1:0] w_cnt_nz;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_valid;
    logic               w_accept;

    assign evt_valid = (r_state == ST_OFFER);
    assign evt_id    = r_evt_id;
    assign w_accept  = evt_valid && evt_ready;
    assign pend_any  = |w_cnt_nz;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic             w_inc;
            logic             w_dec;
            logic             w_sat;

            assign w_inc = done_pulse[gi];
            assign w_dec = w_accept && (r_evt_id == ID_W'(gi));
            // Saturation only counts when the pulse is not cancelled by an accept
            assign w_sat = w_inc && !w_dec && (r_cnt == CNT_MAX);

            always_ff @(posedge nvdla_core_clk) begin
                if (nvdla_core_rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else begin
                    if (w_inc && !w_dec && !w_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_dec && !w_inc) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    r_ovf <= w_sat || (r_ovf && !ovf_clr[gi]);
                end
            end

            assign w_cnt_nz[gi] = |r_cnt;
            assign ovf[gi]      = r_ovf;
        end
    endgenerate

    nv_nvdla_glb_rr_arb #(
        .N (NUM_SRC)
    ) u_rr_arb (
        .i_req   (w_cnt_nz),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state  <= ST_IDLE;
            r_evt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_evt_id <= w_evt_id_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_evt_id_next = r_evt_id;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (seq_en && w_arb_valid) begin
                    w_state_next  = ST_OFFER;
                    w_evt_id_next = w_arb_idx;
                end
            end
            ST_OFFER: begin
                // evt_id is frozen here so the offer stays stable until taken
                if (evt_ready) begin
                    w_state_next  = ST_IDLE;
                    w_rr_ptr_next = (r_evt_id == ID_W'(NUM_SRC - 1)) ? '0 : r_evt_id + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
